example_text_memory_ws: RTL and testbench
=========================================

EXAMPLE_TEXT_MEMORY_WS -- requirements
Module: example_text_memory_ws

Interface
REQ-001 SHALL have parameter filename, default "", hex image loaded into mem at init via $readmemh; empty string means no load.
REQ-002 SHALL have parameter ADDR_BITS, default rv_config::TEXT_BITS - 2, word-address width; depth = 2**ADDR_BITS words.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-004 SHALL have parameter WAIT_STATES, default 1, legal range 0..15, extra cycles between accept and response.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clock in 1 (all state on rising edge); reset in 1 (async, active-high).
REQ-006 SHALL have req_valid in 1, read request present.
REQ-007 SHALL have req_address in ADDR_BITS, word address of read.
REQ-008 SHALL have req_ready out 1, request accepted when req_valid && req_ready at an edge.
REQ-009 SHALL have rsp_valid out 1, rsp_data holds read result.
REQ-010 SHALL have rsp_data out DATA_WIDTH, read data.
REQ-011 SHALL have rsp_ready in 1, consumer takes response when rsp_valid && rsp_ready at an edge.
REQ-012 SHALL have wr_en in 1, program-load write strobe.
REQ-013 SHALL have wr_address in ADDR_BITS, write word address.
REQ-014 SHALL have wr_data in DATA_WIDTH, write data.
REQ-015 SHALL have busy out 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, RESP; req_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-017 IDLE: on accept, latch req_address; go WAIT with wait counter = WAIT_STATES-1 if WAIT_STATES > 0, else go RESP capturing mem[req_address] into rsp_data.
REQ-018 WAIT: decrement counter each cycle; at counter == 0 go RESP, capturing mem[latched address] into rsp_data on that edge.
REQ-019 Accept at edge N SHALL give rsp_valid high after edge N+1+WAIT_STATES.
REQ-020 RESP: rsp_data and rsp_valid SHALL hold stable while rsp_ready low; on handshake go IDLE; no new request accepted in that same cycle.
REQ-021 wr_en SHALL write mem[wr_address] = wr_data at the edge, in any state, with no handshake.
REQ-022 A write to the address being captured on the same edge SHALL return the old (pre-write) word; writes in earlier cycles are visible.
REQ-023 The latched address SHALL be used for capture; req_address changes after accept have no effect.
REQ-024 Address arithmetic SHALL be unsigned ADDR_BITS; no out-of-range case exists.

Reset
REQ-025 Asserted reset SHALL force state IDLE, counter 0, rsp_data 0, latched address 0, rsp_error 0 immediately, without waiting for a clock edge.
REQ-026 Reset mid-transaction SHALL drop the transaction with no response; mem contents SHALL NOT be cleared.
REQ-027 wr_en SHALL be ignored while reset is asserted.

Configuration
REQ-028 With macro EXAMPLE_TEXT_MEMORY_PARITY_EN defined, mem SHALL store an even-parity bit per word (computed on write and on init load); port rsp_error out 1 SHALL be high in RESP when the captured word's parity mismatches.
REQ-029 Without EXAMPLE_TEXT_MEMORY_PARITY_EN, no parity storage and no rsp_error port SHALL exist; all other behaviour is identical.

Verification
REQ-030 WAIT_STATES=1, write 0xDEADBEEF to 0x10, request 0x10 accepted at edge N -> rsp_valid after edge N+2, rsp_data 0xDEADBEEF.
REQ-031 WAIT_STATES=0, back-to-back requests with rsp_ready held high -> one response per 2 cycles, req_ready low during RESP.
REQ-032 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stable; busy stays high; req_ready stays low.
REQ-033 wr_en writing 0x12345678 to the captured address on the capture edge (old value 0xAAAA5555) -> rsp_data 0xAAAA5555; next read returns 0x12345678.
REQ-034 Reset asserted in WAIT with WAIT_STATES=3 -> same cycle: IDLE, rsp_valid 0, rsp_data 0; earlier written words still readable after reset.
REQ-035 PARITY_EN defined, parity bit of address 0x4 forced wrong by backdoor -> read 0x4 gives rsp_error 1 with rsp_valid; clean address gives rsp_error 0.

Source files
------------

// File: rtl/example_text_memory_ws.sv
// -----------------------------------------------------------------------------
// example_text_memory_ws
//
// Word-addressed instruction/text memory with a valid/ready read port, a
// configurable number of wait states and an unhandshaked program-load write
// port.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          asynchronous active-high reset (memory contents are kept)
//   req_valid_i    read request present
//   req_address_i  word address of the read
//   req_ready_o    high in IDLE; request accepted on req_valid_i && req_ready_o
//   rsp_valid_o    high in RESP; rsp_data_o holds the read result
//   rsp_data_o     read data, stable until the response handshake
//   rsp_ready_i    consumer takes the response on rsp_valid_o && rsp_ready_i
//   wr_en_i        program-load write strobe (ignored while rst_i is high)
//   wr_address_i   write word address
//   wr_data_i      write data
//   busy_o         high in any state other than IDLE
//   rsp_error_o    (parity build only) stored parity mismatch on captured word
//
// Optional feature: define EXAMPLE_TEXT_MEMORY_PARITY_EN to store one
// even-parity bit per word and expose rsp_error_o.
//
// Latency: a request accepted at edge N is captured WAIT_STATES edges later,
// so rsp_valid_o is the value seen high at edge N+1+WAIT_STATES. With
// WAIT_STATES = 0 the word is captured on the accept edge itself, which gives
// one response every two cycles when rsp_ready_i is held high.
// -----------------------------------------------------------------------------

package rv_config;
   localparam int TEXT_BITS = 12;
endpackage

module example_text_memory_ws #(
   parameter string filename    = "",
   parameter int    ADDR_BITS   = rv_config::TEXT_BITS - 2,
   parameter int    DATA_WIDTH  = 32,
   parameter int    WAIT_STATES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   input  logic [ADDR_BITS-1:0]  req_address_i,
   output logic                  req_ready_o,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   input  logic                  rsp_ready_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_BITS-1:0]  wr_address_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  busy_o
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
   ,
   output logic                  rsp_error_o
`endif
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   // Counter load value; WAIT is never entered when WAIT_STATES is 0.
   localparam int WS_M1 = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
   localparam logic [3:0] WS_INIT = 4'(WS_M1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
   logic                  par_mem [DEPTH];
   logic                  err_q, err_d;

   // Even parity: stored bit makes the total number of ones even.
   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] word);
      return ^word;
   endfunction

   // True when a word disagrees with its stored parity bit.
   function automatic logic parity_bad(input logic [DATA_WIDTH-1:0] word,
                                       input logic                  par);
      return (^word) != par;
   endfunction
`endif

   // Program-load write port; reads in the same cycle see the old word.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !rst_i) begin
         mem[wr_address_i] <= wr_data_i;
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
         par_mem[wr_address_i] <= parity_of(wr_data_i);
`endif
      end
   end

   // Control state and response registers; memory is deliberately not reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         rsp_data_q <= '0;
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         rsp_data_q <= rsp_data_d;
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
         err_q      <= err_d;
`endif
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      rsp_data_d = rsp_data_q;
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               addr_d = req_address_i;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_INIT;
               end else begin
                  state_d    = ST_RESP;
                  rsp_data_d = mem[req_address_i];
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
                  err_d      = parity_bad(mem[req_address_i], par_mem[req_address_i]);
`endif
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Capture from the latched address, never the live request bus.
            if (cnt_q == 4'd0) begin
               state_d    = ST_RESP;
               rsp_data_d = mem[addr_q];
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
               err_d      = parity_bad(mem[addr_q], par_mem[addr_q]);
`endif
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            // Returning to IDLE here means no accept in the handshake cycle.
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign busy_o      = (state_q != ST_IDLE);
   assign rsp_data_o  = rsp_data_q;
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
   assign rsp_error_o = err_q && (state_q == ST_RESP);
`endif

endmodule

// File: tb/tb_example_text_memory_ws.sv
// -----------------------------------------------------------------------------
// Directed bench for example_text_memory_ws. Three instances share clock and
// reset: index 0 has WAIT_STATES=0, index 1 has 1, index 2 has 3. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_example_text_memory_ws;

   localparam int AW = rv_config::TEXT_BITS - 2;

   logic          clk;
   logic          rst;
   logic          req_valid   [3];
   logic [AW-1:0] req_address [3];
   logic          req_ready   [3];
   logic          rsp_valid   [3];
   logic [31:0]   rsp_data    [3];
   logic          rsp_ready   [3];
   logic          wr_en       [3];
   logic [AW-1:0] wr_address  [3];
   logic [31:0]   wr_data     [3];
   logic          busy        [3];
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
   logic          rsp_error   [3];
`endif

   int tests = 0;
   int fails = 0;

   example_text_memory_ws #(.WAIT_STATES(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid[0]), .req_address_i(req_address[0]), .req_ready_o(req_ready[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]), .rsp_ready_i(rsp_ready[0]),
      .wr_en_i(wr_en[0]), .wr_address_i(wr_address[0]), .wr_data_i(wr_data[0]),
      .busy_o(busy[0])
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
      , .rsp_error_o(rsp_error[0])
`endif
   );

   example_text_memory_ws #(.WAIT_STATES(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid[1]), .req_address_i(req_address[1]), .req_ready_o(req_ready[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]), .rsp_ready_i(rsp_ready[1]),
      .wr_en_i(wr_en[1]), .wr_address_i(wr_address[1]), .wr_data_i(wr_data[1]),
      .busy_o(busy[1])
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
      , .rsp_error_o(rsp_error[1])
`endif
   );

   example_text_memory_ws #(.WAIT_STATES(3)) u_dut2 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid[2]), .req_address_i(req_address[2]), .req_ready_o(req_ready[2]),
      .rsp_valid_o(rsp_valid[2]), .rsp_data_o(rsp_data[2]), .rsp_ready_i(rsp_ready[2]),
      .wr_en_i(wr_en[2]), .wr_address_i(wr_address[2]), .wr_data_i(wr_data[2]),
      .busy_o(busy[2])
`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
      , .rsp_error_o(rsp_error[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int k, input logic [AW-1:0] a, input logic [31:0] d);
      wr_en[k]      = 1'b1;
      wr_address[k] = a;
      wr_data[k]    = d;
      tick();
      wr_en[k]      = 1'b0;
   endtask

   // Complete read with rsp_ready high; ws = that instance's wait states.
   task automatic rd(input int k, input logic [AW-1:0] a, input int ws,
                     input logic [31:0] exp, input string tag);
      chk_b({tag, "_req_ready"}, req_ready[k], 1'b1);
      req_valid[k]   = 1'b1;
      req_address[k] = a;
      rsp_ready[k]   = 1'b1;
      tick();
      req_valid[k] = 1'b0;
      for (int i = 0; i < ws; i++) begin
         chk_b({tag, "_early_valid"}, rsp_valid[k], 1'b0);
         tick();
      end
      chk_b({tag, "_valid"}, rsp_valid[k], 1'b1);
      chk_w({tag, "_data"}, rsp_data[k], exp);
      tick();
      chk_b({tag, "_done_valid"}, rsp_valid[k], 1'b0);
      rsp_ready[k] = 1'b0;
   endtask

`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
   // Read on instance 1 (one wait state) checking rsp_error while in RESP.
   task automatic rd_err(input logic [AW-1:0] a, input logic exp_err, input string tag);
      req_valid[1]   = 1'b1;
      req_address[1] = a;
      rsp_ready[1]   = 1'b0;
      tick();
      req_valid[1] = 1'b0;
      tick();
      chk_b({tag, "_valid"}, rsp_valid[1], 1'b1);
      chk_b({tag, "_err"}, rsp_error[1], exp_err);
      rsp_ready[1] = 1'b1;
      tick();
      rsp_ready[1] = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req_valid[k] = 1'b0; req_address[k] = '0; rsp_ready[k] = 1'b0;
         wr_en[k] = 1'b0; wr_address[k] = '0; wr_data[k] = 32'd0;
      end
      #2 rst = 1'b1;
      tick();
      tick();
      // Reset state
      chk_b("rst_req_ready", req_ready[1], 1'b1);
      chk_b("rst_rsp_valid", rsp_valid[1], 1'b0);
      chk_b("rst_busy", busy[1], 1'b0);
      chk_w("rst_rsp_data", rsp_data[1], 32'h0000_0000);
      rst = 1'b0;
      tick();

      // One wait state: latency, latched address, stall with rsp_ready low
      wr(1, AW'(32'h10), 32'hDEAD_BEEF);
      wr(1, AW'(32'h11), 32'h0BAD_0BAD);
      req_valid[1]   = 1'b1;
      req_address[1] = AW'(32'h10);
      rsp_ready[1]   = 1'b0;
      tick();                                  // accept edge N
      req_valid[1]   = 1'b0;
      req_address[1] = AW'(32'h11);            // must not affect the capture
      chk_b("A_wait_valid", rsp_valid[1], 1'b0);
      chk_b("A_wait_busy", busy[1], 1'b1);
      chk_b("A_wait_req_ready", req_ready[1], 1'b0);
      tick();                                  // edge N+1: valid seen at N+2
      req_valid[1] = 1'b1;                     // must be ignored in RESP
      for (int i = 0; i < 5; i++) begin
         chk_b("A_hold_valid", rsp_valid[1], 1'b1);
         chk_w("A_hold_data", rsp_data[1], 32'hDEAD_BEEF);
         chk_b("A_hold_busy", busy[1], 1'b1);
         chk_b("A_hold_req_ready", req_ready[1], 1'b0);
         tick();
      end
      chk_b("A_hold_valid_last", rsp_valid[1], 1'b1);
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b1;
      tick();
      rsp_ready[1] = 1'b0;
      chk_b("A_idle_valid", rsp_valid[1], 1'b0);
      chk_b("A_idle_req_ready", req_ready[1], 1'b1);
      chk_b("A_idle_busy", busy[1], 1'b0);

      // Write to the captured address on the capture edge returns the old word
      wr(1, AW'(32'h20), 32'hAAAA_5555);
      req_valid[1]   = 1'b1;
      req_address[1] = AW'(32'h20);
      rsp_ready[1]   = 1'b0;
      tick();
      req_valid[1]  = 1'b0;
      wr_en[1]      = 1'b1;
      wr_address[1] = AW'(32'h20);
      wr_data[1]    = 32'h1234_5678;
      tick();
      wr_en[1] = 1'b0;
      chk_b("B_valid", rsp_valid[1], 1'b1);
      chk_w("B_old_data", rsp_data[1], 32'hAAAA_5555);
      rsp_ready[1] = 1'b1;
      tick();
      rsp_ready[1] = 1'b0;
      rd(1, AW'(32'h20), 1, 32'h1234_5678, "B_reread");

      // Zero wait states, back-to-back with rsp_ready held high
      for (int i = 1; i <= 3; i++) wr(0, AW'(i), 32'h1111_1111 * 32'(i));
      req_valid[0] = 1'b1;
      rsp_ready[0] = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         req_address[0] = AW'(i);
         chk_b("C_req_ready_idle", req_ready[0], 1'b1);
         tick();
         chk_b("C_valid", rsp_valid[0], 1'b1);
         chk_w("C_data", rsp_data[0], 32'h1111_1111 * 32'(i));
         chk_b("C_req_ready_resp", req_ready[0], 1'b0);
         tick();
         chk_b("C_valid_gap", rsp_valid[0], 1'b0);
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b0;

      // Three wait states: latency, then reset in the middle of WAIT
      wr(2, AW'(32'h5), 32'hCAFE_F00D);
      rd(2, AW'(32'h5), 3, 32'hCAFE_F00D, "D_lat3");
      req_valid[2]   = 1'b1;
      req_address[2] = AW'(32'h5);
      rsp_ready[2]   = 1'b0;
      tick();
      req_valid[2] = 1'b0;
      tick();
      chk_b("D_wait_busy", busy[2], 1'b1);
      #2 rst = 1'b1;                           // between edges
      #1;
      chk_b("D_rst_valid", rsp_valid[2], 1'b0);
      chk_w("D_rst_data", rsp_data[2], 32'h0000_0000);
      chk_b("D_rst_req_ready", req_ready[2], 1'b1);
      chk_b("D_rst_busy", busy[2], 1'b0);
      wr_en[2]      = 1'b1;                    // ignored while in reset
      wr_address[2] = AW'(32'h5);
      wr_data[2]    = 32'h0000_0000;
      tick();
      tick();
      wr_en[2] = 1'b0;
      rst = 1'b0;
      tick();
      rd(2, AW'(32'h5), 3, 32'hCAFE_F00D, "D_after_rst");
      rd(1, AW'(32'h10), 1, 32'hDEAD_BEEF, "D_inst1_kept");

`ifdef EXAMPLE_TEXT_MEMORY_PARITY_EN
      // Corrupted stored parity on 0x4 is flagged; clean word at 0x8 is not
      wr(1, AW'(32'h4), 32'h0000_0001);
      wr(1, AW'(32'h8), 32'h0000_0003);
      u_dut1.par_mem[4] = ~u_dut1.par_mem[4];
      rd_err(AW'(32'h4), 1'b1, "E_bad_parity");
      rd_err(AW'(32'h8), 1'b0, "E_good_parity");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
